// File: rtl/rle_pkg.sv
// Types shared by the run-length encoder and decoder: default run width,
// decoder FSM states and the {bit, count} pair carried between them.
package rle_pkg;

   localparam int RLE_COUNT_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } rle_state_t;

   typedef struct packed {
      logic                   sym;
      logic [RLE_COUNT_W-1:0] count;
   } rle_pair_t;

endpackage

// File: rtl/rle_decoder_if.sv
// Compressed-pair input stream and single-bit output stream of the RLE decoder.
// The master modport is the side that produces pairs and consumes beats.
interface rle_decoder_if
   import rle_pkg::*;
#(
   parameter int COUNT_W = RLE_COUNT_W
);

   logic               in_valid;
   logic               in_ready;
   logic               in_bit;
   logic [COUNT_W-1:0] in_count;
   logic               out_valid;
   logic               out_ready;
   logic               out_bit;
   logic               out_last;

   modport master (
      output in_valid, in_bit, in_count, out_ready,
      input  in_ready, out_valid, out_bit, out_last
   );

   modport slave (
      input  in_valid, in_bit, in_count, out_ready,
      output in_ready, out_valid, out_bit, out_last
   );

endinterface

// File: rtl/rle_skid_buf.sv
// One-entry valid/ready holding register with a registered ready flag.
// Ready stays low during reset and rises on the first edge after release.
module rle_skid_buf
   import rle_pkg::*;
#(
   parameter int DATA_W = $bits(rle_pair_t)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data
);

   logic valid_next;

   // Ready is only high while empty, so a push and a pop never coincide.
   always_comb begin
      valid_next = m_valid;
      if (s_valid && s_ready) begin
         valid_next = 1'b1;
      end else if (m_valid && m_ready) begin
         valid_next = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         m_valid <= 1'b0;
         s_ready <= 1'b0;
         m_data  <= '0;
      end else begin
         m_valid <= valid_next;
         s_ready <= !valid_next;
         if (s_valid && s_ready) begin
            m_data <= s_data;
         end
      end
   end

endmodule

// File: rtl/rle_decoder.sv
// Bit-level run-length decoder: expands {bit, count} pairs into a serial bit stream.
// Define RLE_DEC_SKID_EN to add a one-entry pending-pair buffer for gapless runs.
module rle_decoder
   import rle_pkg::*;
#(
   parameter int COUNT_W = RLE_COUNT_W
) (
   input  logic         clock,
   input  logic         reset,
   rle_decoder_if.slave bus
);

   localparam logic [COUNT_W-1:0] ONE = COUNT_W'(1);

   rle_state_t         state;
   rle_state_t         state_next;
   logic [COUNT_W-1:0] remaining;
   logic [COUNT_W-1:0] remaining_next;
   logic               symbol;
   logic               symbol_next;

   logic               out_valid_q;
   logic               out_bit_q;
   logic               out_last_q;
   logic               out_valid_next;
   logic               out_bit_next;
   logic               out_last_next;

   logic               in_ready_w;
   logic               in_fire;
   logic               out_fire;

   assign in_fire  = bus.in_valid && in_ready_w && (state == IDLE);
   assign out_fire = out_valid_q && bus.out_ready;

`ifdef RLE_DEC_SKID_EN
   logic               pend_valid;
   logic               pend_pop;
   logic               pend_sym;
   logic [COUNT_W-1:0] pend_count;
   logic [COUNT_W:0]   pend_data;

   // Pairs offered during a run are parked; in IDLE an empty buffer is bypassed.
   rle_skid_buf #(
      .DATA_W (COUNT_W + 1)
   ) u_skid (
      .clock   (clock),
      .reset   (reset),
      .s_valid (bus.in_valid && (state == RUN)),
      .s_ready (in_ready_w),
      .s_data  ({bus.in_bit, bus.in_count}),
      .m_valid (pend_valid),
      .m_ready (pend_pop),
      .m_data  (pend_data)
   );

   assign pend_sym   = pend_data[COUNT_W];
   assign pend_count = pend_data[COUNT_W-1:0];
`else
   logic in_ready_q;
   logic in_ready_next;

   assign in_ready_w = in_ready_q;
`endif

   // State register; every output is a flop loaded from its next value.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state       <= IDLE;
         remaining   <= '0;
         symbol      <= 1'b0;
         out_valid_q <= 1'b0;
         out_bit_q   <= 1'b0;
         out_last_q  <= 1'b0;
`ifndef RLE_DEC_SKID_EN
         in_ready_q  <= 1'b0;
`endif
      end else begin
         state       <= state_next;
         remaining   <= remaining_next;
         symbol      <= symbol_next;
         out_valid_q <= out_valid_next;
         out_bit_q   <= out_bit_next;
         out_last_q  <= out_last_next;
`ifndef RLE_DEC_SKID_EN
         in_ready_q  <= in_ready_next;
`endif
      end
   end

   // Next-state logic: zero-length pairs are consumed without entering RUN.
   always_comb begin
      state_next     = state;
      remaining_next = remaining;
      symbol_next    = symbol;
`ifdef RLE_DEC_SKID_EN
      pend_pop       = 1'b0;
`endif
      case (state)
         IDLE: begin
`ifdef RLE_DEC_SKID_EN
            if (pend_valid) begin
               pend_pop = 1'b1;
               if (pend_count != '0) begin
                  state_next     = RUN;
                  remaining_next = pend_count;
                  symbol_next    = pend_sym;
               end
            end else
`endif
            if (in_fire && (bus.in_count != '0)) begin
               state_next     = RUN;
               remaining_next = bus.in_count;
               symbol_next    = bus.in_bit;
            end
         end
         RUN: begin
            if (out_fire) begin
               if (remaining == ONE) begin
                  state_next     = IDLE;
                  remaining_next = '0;
`ifdef RLE_DEC_SKID_EN
                  // A parked nonzero pair follows the final beat with no bubble.
                  if (pend_valid) begin
                     pend_pop = 1'b1;
                     if (pend_count != '0) begin
                        state_next     = RUN;
                        remaining_next = pend_count;
                        symbol_next    = pend_sym;
                     end
                  end
`endif
               end else begin
                  remaining_next = remaining - ONE;
               end
            end
         end
         default: begin
            state_next     = IDLE;
            remaining_next = '0;
         end
      endcase
   end

   // Output values for the next cycle, derived from the next state.
   always_comb begin
      out_valid_next = (state_next == RUN);
      out_bit_next   = symbol_next;
      out_last_next  = (state_next == RUN) && (remaining_next == ONE);
`ifndef RLE_DEC_SKID_EN
      in_ready_next  = (state_next == IDLE);
`endif
   end

   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = out_valid_q;
   assign bus.out_bit   = out_bit_q;
   assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_rle_decoder.sv
// Directed self-checking bench for rle_decoder; expectations follow RLE_DEC_SKID_EN.
`timescale 1ns/1ps
module tb_rle_decoder;
   import rle_pkg::*;

   logic clock;
   logic reset;
   int   checks;
   int   errors;

   rle_decoder_if #(.COUNT_W(RLE_COUNT_W)) bus ();

   rle_decoder #(.COUNT_W(RLE_COUNT_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Hard stop in case the design stalls the stimulus entirely.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic send_pair(input logic b, input logic [RLE_COUNT_W-1:0] c);
      int waited;
      waited = 0;
      while (bus.in_ready !== 1'b1 && waited < 20) begin
         cycle();
         waited++;
      end
      if (bus.in_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("[TB] FAIL send_wait: in_ready=%b required 1", bus.in_ready);
      end
      bus.in_valid = 1'b1;
      bus.in_bit   = b;
      bus.in_count = c;
      cycle();
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_bit    = 1'b0;
      bus.in_count  = '0;
      bus.out_ready = 1'b0;
      repeat (3) cycle();
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_in_ready: got %b required 0", bus.in_ready);
      end
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_out_valid: got %b required 0", bus.out_valid);
      end
      checks++;
      if (bus.out_bit !== 1'b0 || bus.out_last !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_bit_last: got %b%b required 00", bus.out_bit, bus.out_last);
      end
      reset = 1'b1;
      cycle();
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL release_in_ready: got %b required 1", bus.in_ready);
      end
   endtask

   task automatic test_basic();
      bus.out_ready = 1'b1;
      send_pair(1'b1, 8'd3);
      checks++;
`ifdef RLE_DEC_SKID_EN
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL basic_run_ready: got %b required 1", bus.in_ready);
      end
`else
      if (bus.in_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL basic_run_ready: got %b required 0", bus.in_ready);
      end
`endif
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_bit !== 1'b1 || bus.out_last !== (k == 2)) begin
            errors++;
            $display("[TB] FAIL basic_beat%0d: valid/bit/last=%b%b%b required 11%b",
                     k, bus.out_valid, bus.out_bit, bus.out_last, (k == 2));
         end
         cycle();
      end
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL basic_end: valid=%b ready=%b required 0 1", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_zero_run();
      bus.out_ready = 1'b1;
      send_pair(1'b0, 8'd0);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL zero_consumed: valid=%b ready=%b required 0 1", bus.out_valid, bus.in_ready);
      end
      send_pair(1'b1, 8'd2);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_bit !== 1'b1 || bus.out_last !== (k == 1)) begin
            errors++;
            $display("[TB] FAIL zero_next_beat%0d: valid/bit/last=%b%b%b required 11%b",
                     k, bus.out_valid, bus.out_bit, bus.out_last, (k == 1));
         end
         cycle();
      end
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL zero_next_end: valid=%b required 0", bus.out_valid);
      end
   endtask

   task automatic test_backpressure();
      logic [6:0] pat;
      int         rem;
      pat = 7'b1011001;
      rem = 4;
      bus.out_ready = 1'b1;
      send_pair(1'b1, 8'd4);
      for (int t = 0; t < 7; t++) begin
         bus.out_ready = pat[t];
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_bit !== 1'b1 || bus.out_last !== (rem == 1)) begin
            errors++;
            $display("[TB] FAIL stall_t%0d: valid/bit/last=%b%b%b required 11%b",
                     t, bus.out_valid, bus.out_bit, bus.out_last, (rem == 1));
         end
         if (pat[t]) rem--;
         cycle();
      end
      bus.out_ready = 1'b1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL stall_end: valid=%b required 0 after 4 transfers", bus.out_valid);
      end
   endtask

   task automatic test_back_to_back();
      bus.out_ready = 1'b1;
`ifdef RLE_DEC_SKID_EN
      send_pair(1'b0, 8'd2);
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL b2b_ready: got %b required 1", bus.in_ready);
      end
      bus.in_valid = 1'b1;
      bus.in_bit   = 1'b1;
      bus.in_count = 8'd2;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_bit !== (k >= 2) || bus.out_last !== (k == 1 || k == 3)) begin
            errors++;
            $display("[TB] FAIL b2b_beat%0d: valid/bit/last=%b%b%b required 1%b%b",
                     k, bus.out_valid, bus.out_bit, bus.out_last, (k >= 2), (k == 1 || k == 3));
         end
         cycle();
         bus.in_valid = 1'b0;
      end
`else
      send_pair(1'b0, 8'd2);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_bit !== 1'b0 || bus.out_last !== (k == 1)) begin
            errors++;
            $display("[TB] FAIL b2b_first%0d: valid/bit/last=%b%b%b required 10%b",
                     k, bus.out_valid, bus.out_bit, bus.out_last, (k == 1));
         end
         cycle();
      end
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL b2b_bubble: valid=%b required 0", bus.out_valid);
      end
      send_pair(1'b1, 8'd2);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_bit !== 1'b1 || bus.out_last !== (k == 1)) begin
            errors++;
            $display("[TB] FAIL b2b_second%0d: valid/bit/last=%b%b%b required 11%b",
                     k, bus.out_valid, bus.out_bit, bus.out_last, (k == 1));
         end
         cycle();
      end
`endif
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL b2b_end: valid=%b required 0", bus.out_valid);
      end
   endtask

   task automatic test_long_run();
      int beats;
      beats = 0;
      bus.out_ready = 1'b1;
      send_pair(1'b1, 8'd255);
      for (int c = 0; c < 300; c++) begin
         if (bus.out_valid !== 1'b1) break;
         beats++;
         checks++;
         if (bus.out_bit !== 1'b1 || bus.out_last !== (beats == 255)) begin
            errors++;
            $display("[TB] FAIL long_beat%0d: bit/last=%b%b required 1%b",
                     beats, bus.out_bit, bus.out_last, (beats == 255));
         end
         cycle();
      end
      checks++;
      if (beats != 255) begin
         errors++; $display("[TB] FAIL long_count: got %0d beats required 255", beats);
      end
   endtask

   task automatic test_reset_mid_run();
      bus.out_ready = 1'b1;
      send_pair(1'b1, 8'd5);
      bus.in_valid = 1'b1;
      bus.in_bit   = 1'b1;
      bus.in_count = 8'd3;
      cycle();
      bus.in_valid = 1'b0;
      cycle();
      checks++;
      if (bus.out_valid !== 1'b1) begin
         errors++; $display("[TB] FAIL midrun_active: valid=%b required 1", bus.out_valid);
      end
      reset = 1'b0;
      cycle();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_bit !== 1'b0 || bus.out_last !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midrun_reset: valid/ready/bit/last=%b%b%b%b required 0000",
                  bus.out_valid, bus.in_ready, bus.out_bit, bus.out_last);
      end
      reset = 1'b1;
      cycle();
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL midrun_release: ready=%b required 1", bus.in_ready);
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (bus.out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL midrun_residual%0d: valid=%b required 0", k, bus.out_valid);
         end
         cycle();
      end
      send_pair(1'b0, 8'd1);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_bit !== 1'b0 || bus.out_last !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midrun_new: valid/bit/last=%b%b%b required 101",
                  bus.out_valid, bus.out_bit, bus.out_last);
      end
      cycle();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL midrun_new_end: valid=%b required 0", bus.out_valid);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_zero_run();
      test_backpressure();
      test_back_to_back();
      test_long_run();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
